// File: rtl/spi_regfile_pkg.sv
// Shared types and frame-geometry helpers for the SPI register-file peripheral.
// The optional readback path is enabled by defining SPI_READBACK_EN.
package spi_regfile_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    COMMIT
  } state_t;

  localparam int ERR_CNT_W = 8;
  localparam logic RW_WRITE = 1'b1;

  function automatic int frame_width(input int addr_w, input int data_w);
    return 1 + addr_w + data_w;
  endfunction

  // The R/W flag is the first bit on the wire, so it lands in the frame MSB.
  function automatic int rw_bit_pos(input int addr_w, input int data_w);
    return addr_w + data_w;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser plus a history flop for edge detection on one SPI pin.
// RST_VAL is the idle level, so leaving reset never produces a false edge.
module spi_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [2:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {3{RST_VAL}};
    end else begin
      sync_q <= {sync_q[1:0], din};
    end
  end

  assign level = sync_q[1];
  assign rise  = sync_q[1] & ~sync_q[2];
  assign fall  = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/spi_regfile_peripheral.sv
// SPI mode-0 target holding NUM_REGS configuration registers, with frame error counting.
// Define SPI_READBACK_EN to add CIPO readback of the addressed register in read frames.
module spi_regfile_peripheral
  import spi_regfile_pkg::*;
#(
  parameter int NUM_REGS = 5,
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 7
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         sclk,
  input  logic                         copi,
  input  logic                         ncs,
  output logic                         cipo,
  output logic [NUM_REGS*DATA_W-1:0]   regs,
  output logic [NUM_REGS-1:0]          wr_strobe,
  output logic                         frame_err,
  output logic [ERR_CNT_W-1:0]         err_count
);

  localparam int FRAME_W = frame_width(ADDR_W, DATA_W);
  localparam int RW_POS  = rw_bit_pos(ADDR_W, DATA_W);
  localparam int CNT_W   = $clog2(FRAME_W + 2);

  localparam logic [CNT_W-1:0] CNT_FULL     = CNT_W'(FRAME_W);
  localparam logic [CNT_W-1:0] CNT_MAX      = CNT_W'(FRAME_W + 1);
  localparam logic [CNT_W-1:0] CNT_PRE_DATA = CNT_W'(ADDR_W);

  logic sclk_level, sclk_rise, sclk_fall;
  logic copi_level, copi_rise, copi_fall;
  logic ncs_level, ncs_rise, ncs_fall;

  spi_sync_edge #(.RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst(rst), .din(sclk),
    .level(sclk_level), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_sync_edge #(.RST_VAL(1'b0)) u_sync_copi (
    .clk(clk), .rst(rst), .din(copi),
    .level(copi_level), .rise(copi_rise), .fall(copi_fall)
  );

  spi_sync_edge #(.RST_VAL(1'b1)) u_sync_ncs (
    .clk(clk), .rst(rst), .din(ncs),
    .level(ncs_level), .rise(ncs_rise), .fall(ncs_fall)
  );

  logic unused_sync;
  assign unused_sync = ^{sclk_level, sclk_fall, copi_rise, copi_fall, ncs_level};

  state_t state_q, state_d;

  logic [FRAME_W-1:0]         shift_q;
  logic [FRAME_W-1:0]         shift_next;
  logic [CNT_W-1:0]           cnt_q;
  logic                       start_pending_q;
  logic [NUM_REGS*DATA_W-1:0] regs_q;
  logic [NUM_REGS-1:0]        strobe_q;
  logic                       err_q;
  logic [ERR_CNT_W-1:0]       err_cnt_q;

  logic                       frame_rw;
  logic [ADDR_W-1:0]          frame_addr;
  logic [DATA_W-1:0]          frame_data;
  logic                       addr_ok;
  logic                       frame_ok;

  assign shift_next = {shift_q[FRAME_W-2:0], copi_level};
  assign frame_rw   = shift_q[RW_POS];
  assign frame_addr = shift_q[RW_POS-1 -: ADDR_W];
  assign frame_data = shift_q[DATA_W-1:0];
  assign addr_ok    = {1'b0, frame_addr} < (ADDR_W + 1)'(NUM_REGS);
  assign frame_ok   = (cnt_q == CNT_FULL) && addr_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A chip-select fall landing during COMMIT is remembered so the next frame is not lost.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (ncs_fall || start_pending_q) state_d = SHIFT;
      SHIFT:   if (ncs_rise) state_d = COMMIT;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q         <= '0;
      cnt_q           <= '0;
      start_pending_q <= 1'b0;
    end else begin
      start_pending_q <= (state_q == COMMIT) && ncs_fall;
      if (state_q == IDLE) begin
        if (state_d == SHIFT) begin
          shift_q <= '0;
          cnt_q   <= '0;
        end
      end else if (state_q == SHIFT && !ncs_rise && sclk_rise) begin
        shift_q <= shift_next;
        if (cnt_q != CNT_MAX) begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      regs_q    <= '0;
      strobe_q  <= '0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      strobe_q <= '0;
      err_q    <= 1'b0;
      if (state_q == COMMIT) begin
        if (!frame_ok) begin
          err_q <= 1'b1;
          if (err_cnt_q != '1) begin
            err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
          end
        end else if (frame_rw == RW_WRITE) begin
          for (int i = 0; i < NUM_REGS; i++) begin
            if (frame_addr == ADDR_W'(i)) begin
              regs_q[i*DATA_W +: DATA_W] <= frame_data;
              strobe_q[i]                <= 1'b1;
            end
          end
        end
      end
    end
  end

  assign regs      = regs_q;
  assign wr_strobe = strobe_q;
  assign frame_err = err_q;
  assign err_count = err_cnt_q;

`ifdef SPI_READBACK_EN
  logic [DATA_W-1:0] out_sr_q;
  logic [DATA_W-1:0] rd_word;
  logic              out_active_q;
  logic              cipo_q;

  // Once the header is in, shift_next holds {rw, addr} in its low bits.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (shift_next[ADDR_W-1:0] == ADDR_W'(i)) begin
        rd_word = regs_q[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_sr_q     <= '0;
      out_active_q <= 1'b0;
      cipo_q       <= 1'b0;
    end else if (state_q != SHIFT || ncs_rise) begin
      out_sr_q     <= '0;
      out_active_q <= 1'b0;
      cipo_q       <= 1'b0;
    end else if (sclk_rise && cnt_q == CNT_PRE_DATA && shift_next[ADDR_W] != RW_WRITE) begin
      out_sr_q     <= rd_word;
      out_active_q <= 1'b1;
    end else if (sclk_fall && out_active_q) begin
      cipo_q   <= out_sr_q[DATA_W-1];
      out_sr_q <= out_sr_q << 1;
    end
  end

  assign cipo = cipo_q;
`else
  assign cipo = 1'b0;
`endif

endmodule

// File: tb/tb_spi_regfile_peripheral.sv
// Directed self-checking bench for spi_regfile_peripheral (default 5 x 8-bit registers).
// Readback expectations follow SPI_READBACK_EN when the bench is compiled with it.
module tb_spi_regfile_peripheral;

  logic        clk;
  logic        rst;
  logic        sclk;
  logic        copi;
  logic        ncs;
  logic        cipo;
  logic [39:0] regs;
  logic [4:0]  wr_strobe;
  logic        frame_err;
  logic [7:0]  err_count;

  int          checks;
  int          passed;
  int          failed;
  logic [31:0] rxBits;
  logic [15:0] partial;
  logic [15:0] rbExpect;

  spi_regfile_peripheral #(
    .NUM_REGS(5),
    .DATA_W(8),
    .ADDR_W(7)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sclk(sclk),
    .copi(copi),
    .ncs(ncs),
    .cipo(cipo),
    .regs(regs),
    .wr_strobe(wr_strobe),
    .frame_err(frame_err),
    .err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic waitClk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic toEdge(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) passed++;
    else begin
      failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Drives one frame MSB first, sclk half period of 5 clk; samples cipo before each rise.
  task automatic applyStimulus(input logic [31:0] frame, input int nbits);
    rxBits = '0;
    ncs = 1'b0;
    waitClk(5);
    for (int i = nbits - 1; i >= 0; i--) begin
      copi = frame[i];
      waitClk(5);
      rxBits = {rxBits[30:0], cipo};
      sclk = 1'b1;
      waitClk(5);
      sclk = 1'b0;
    end
    waitClk(5);
    ncs = 1'b1;
  endtask

  initial begin
    checks = 0;
    passed = 0;
    failed = 0;
    rxBits = '0;
    rst  = 1'b1;
    sclk = 1'b0;
    copi = 1'b0;
    ncs  = 1'b1;
`ifdef SPI_READBACK_EN
    rbExpect = 16'h003C;
`else
    rbExpect = 16'h0000;
`endif

    waitClk(4);
    checkOutput("reset_regs", regs, 40'h0);
    checkOutput("reset_strobe", wr_strobe, 5'h0);
    checkOutput("reset_frame_err", frame_err, 1'b0);
    checkOutput("reset_err_count", err_count, 8'h0);
    checkOutput("reset_cipo", cipo, 1'b0);
    rst = 1'b0;
    waitClk(6);

    $display("[TB] write 0xA5 to addr 2");
    applyStimulus(32'h82A5, 16);
    toEdge(3);
    checkOutput("wr2_regs_before", regs, 40'h0);
    checkOutput("wr2_strobe_before", wr_strobe, 5'h0);
    toEdge(1);
    checkOutput("wr2_regs", regs, 40'h00_00_A5_00_00);
    checkOutput("wr2_strobe", wr_strobe, 5'b00100);
    checkOutput("wr2_no_err", frame_err, 1'b0);
    toEdge(1);
    checkOutput("wr2_strobe_end", wr_strobe, 5'h0);
    waitClk(6);

    $display("[TB] write to out-of-range addr 5");
    applyStimulus(32'h8577, 16);
    toEdge(4);
    checkOutput("addr5_err", frame_err, 1'b1);
    checkOutput("addr5_count", err_count, 8'd1);
    checkOutput("addr5_strobe", wr_strobe, 5'h0);
    checkOutput("addr5_regs", regs, 40'h00_00_A5_00_00);
    toEdge(1);
    checkOutput("addr5_err_end", frame_err, 1'b0);
    waitClk(6);

    $display("[TB] reset, write addr 4, then short and long frames");
    rst = 1'b1;
    waitClk(3);
    rst = 1'b0;
    waitClk(6);
    checkOutput("rst2_count", err_count, 8'd0);
    applyStimulus(32'h845A, 16);
    toEdge(4);
    checkOutput("wr4_regs", regs, 40'h5A_00_00_00_00);
    checkOutput("wr4_strobe", wr_strobe, 5'b10000);
    waitClk(6);
    applyStimulus(32'h0000_4123, 15);
    toEdge(4);
    checkOutput("short_err", frame_err, 1'b1);
    checkOutput("short_strobe", wr_strobe, 5'h0);
    waitClk(6);
    applyStimulus(32'h0001_0203, 17);
    toEdge(4);
    checkOutput("long_err", frame_err, 1'b1);
    checkOutput("long_count", err_count, 8'd2);
    checkOutput("long_regs", regs, 40'h5A_00_00_00_00);
    waitClk(6);

    $display("[TB] write 0x3C to addr 1 and read it back");
    applyStimulus(32'h813C, 16);
    toEdge(4);
    checkOutput("wr1_regs", regs, 40'h5A_00_00_3C_00);
    waitClk(6);
    applyStimulus(32'h0100, 16);
    checkOutput("rd1_cipo_bits", rxBits[15:0], rbExpect);
    toEdge(4);
    checkOutput("rd1_strobe", wr_strobe, 5'h0);
    checkOutput("rd1_no_err", frame_err, 1'b0);
    checkOutput("rd1_count", err_count, 8'd2);
    checkOutput("rd1_regs", regs, 40'h5A_00_00_3C_00);
    checkOutput("rd1_cipo_idle", cipo, 1'b0);
    waitClk(6);

    $display("[TB] reset after 9 bits of a frame");
    partial = 16'h8122;
    ncs = 1'b0;
    waitClk(5);
    for (int i = 15; i >= 7; i--) begin
      copi = partial[i];
      waitClk(5);
      sclk = 1'b1;
      waitClk(5);
      sclk = 1'b0;
    end
    rst = 1'b1;
    waitClk(2);
    ncs  = 1'b1;
    copi = 1'b0;
    waitClk(4);
    checkOutput("midrst_regs", regs, 40'h0);
    checkOutput("midrst_count", err_count, 8'd0);
    rst = 1'b0;
    waitClk(6);
    applyStimulus(32'h8011, 16);
    toEdge(4);
    checkOutput("postrst_regs", regs, 40'h00_00_00_00_11);
    checkOutput("postrst_strobe", wr_strobe, 5'b00001);
    checkOutput("postrst_count", err_count, 8'd0);
    waitClk(6);

    $display("[TB] 300 empty frames for counter saturation");
    for (int n = 0; n < 254; n++) begin
      ncs = 1'b0;
      waitClk(5);
      ncs = 1'b1;
      waitClk(7);
    end
    checkOutput("sat_254", err_count, 8'd254);
    for (int n = 0; n < 46; n++) begin
      ncs = 1'b0;
      waitClk(5);
      ncs = 1'b1;
      waitClk(7);
    end
    checkOutput("sat_255", err_count, 8'd255);
    checkOutput("sat_regs", regs, 40'h00_00_00_00_11);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/spi_regfile_peripheral.md
# spi_regfile_peripheral

Parametrised SPI (mode 0) register-file target. It receives framed write (and optionally read) transactions from an external SPI controller. It holds `NUM_REGS` configuration registers of `DATA_W` bits and presents them, flattened, to downstream blocks such as the PWM generators. It extends the fixed two-register, write-only peripheral with:
- a configurable register count and width
- per-register write strobes
- frame error detection and counting
- optional CIPO readback

## Interface
- `NUM_REGS`, 5: number of registers; 1..2^ADDR_W.
- `DATA_W`, 8: register and data-field width.
- `ADDR_W`, 7: address-field width.
- `clk`  in  1  system clock; all logic in this domain.
- `rst`  in  1  reset, synchronous, active-high.
- `sclk`  in  1  SPI clock (asynchronous to `clk`).
- `copi`  in  1  controller-out data.
- `ncs`  in  1  chip select, active low.
- `cipo`  out  1  peripheral-out data; 0 when idle or readback compiled out.
- `regs`  out  NUM_REGS*DATA_W  register contents; reg i at [i*DATA_W +: DATA_W].
- `wr_strobe`  out  NUM_REGS  one-cycle pulse on the cycle reg i takes a new value.
- `frame_err`  out  1  one-cycle pulse per rejected frame.
- `err_count`  out  8  saturating count of rejected frames.

## Operation
- Frame layout:
  - FRAME_W = 1+ADDR_W+DATA_W bits, sent MSB first.
  - bit[FRAME_W-1] is R/W (1 = write), followed by address, then data.
- Synchronisation:
  - `sclk`, `copi` and `ncs` each pass through 2 flops, plus a third stage for edge detection.
  - Reset values are idle: sclk 0, copi 0, ncs 1, so reset never creates a spurious edge.
- FSM states:
  - IDLE: on synced `ncs` fall, clear shift register and bit count, go to SHIFT.
  - SHIFT: on each synced `sclk` rise, shift in synced `copi`; bit count increments and saturates at FRAME_W+1. On synced `ncs` rise, go to COMMIT.
  - COMMIT: one cycle, validate and apply the frame, then go to IDLE.
- Frame is valid only when:
  - bit count == FRAME_W exactly, and
  - address < NUM_REGS.
- Valid write: reg[addr] <= data and `wr_strobe[addr]` pulses, even if the value is unchanged.
- Invalid frame (short, long or out-of-range, write or read):
  - no register changes
  - `frame_err` pulses
  - `err_count` increments, saturating at 255
- Valid read frame: no register change, no strobe.
- `sclk` edges while `ncs` is high are ignored.
- Reset clears all registers, `wr_strobe`, `frame_err`, `err_count` and `cipo` to 0 and returns the FSM to IDLE. A frame in progress at reset is discarded; the next frame starts at the next `ncs` fall.

## Timing
- Edge detection lags the pins by 3 `clk` cycles.
- `regs` and `wr_strobe` update on the `clk` edge that ends COMMIT. This is 4 `clk` cycles after `ncs` rises at the pin.
- `frame_err` and the `err_count` increment occur on the same edge as that update.
- Minimum `sclk` high and low time is 4 `clk` periods (`sclk` ≤ clk/8).
- Minimum `ncs` high time between frames is 4 `clk` periods.
- A synced `ncs` rise in the same cycle as a synced `sclk` rise: `ncs` wins; that bit is not shifted.
- Back-to-back frames: a new `ncs` fall seen in COMMIT is taken in the following IDLE cycle, so no frame is lost.

## Configuration
- `SPI_READBACK_EN` defined:
  - In a read frame, once 1+ADDR_W bits are received, reg[addr] is latched into an output shift register (0 if address ≥ NUM_REGS).
  - Its MSB drives `cipo` from the next synced `sclk` fall.
  - One bit shifts out per subsequent fall.
  - `cipo` returns to 0 when `ncs` goes high.
- `SPI_READBACK_EN` undefined:
  - `cipo` is constant 0 and there is no output shift logic.
  - Read frames are still validated for length and address (errors counted) but otherwise ignored.

## Structure
- Package `spi_regfile_pkg`:
  - FSM state enum (IDLE, SHIFT, COMMIT)
  - FRAME_W derivation function
  - R/W bit position and ERR_CNT_W = 8 constants
- Sub-module `spi_sync_edge`: one instance per SPI input. It provides the 3-flop synchroniser with a programmable reset value and outputs `level`, `rise` and `fall`.

## Test plan
- Write 0xA5 to addr 2 (frame 0x82A5) → `regs[23:16]` = 0xA5 four clk after `ncs` rise; `wr_strobe` = 5'b00100 for one cycle; other regs stay 0.
- Write to addr 5 with NUM_REGS = 5 → no register change, `frame_err` pulses once, `err_count` = 1.
- 15-bit frame and 17-bit frame → both rejected, `err_count` = 2, `regs` unchanged.
- With `SPI_READBACK_EN`: write 0x3C to addr 1, then read addr 1 → `cipo` shifts 0,0,1,1,1,1,0,0 on data-phase falls. Without the macro → `cipo` stays 0.
- Assert `rst` mid-frame after 9 bits, release, then send a full write of 0x11 to addr 0 → registers were 0 after reset; afterwards reg0 = 0x11 and `err_count` = 0.
- 300 invalid frames → `err_count` saturates at 255.
